// File: rtl/uart_digest_sender.sv
// Serialises a captured hash digest into one-character UART send requests,
// as lowercase hex (or raw bytes) followed by an optional CR LF.
module uart_digest_sender #(
    parameter int NUM_BYTES   = 32,
    parameter bit HEX_ASCII   = 1'b1,
    parameter bit APPEND_CRLF = 1'b1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] digest,
    input  logic                   digest_valid,
    output logic                   digest_ready,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    output logic                   active,
    output logic                   done
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int NDIG  = NUM_BYTES * (HEX_ASCII ? 2 : 1);
    localparam int TOTAL = NDIG + (APPEND_CRLF ? 2 : 0);
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [7:0]    NDIG_C   = 8'(NDIG);
    localparam logic [7:0]    TOTAL_C  = 8'(TOTAL);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WSTART,
        S_WDONE,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] w_shift_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_send;
    logic          w_send_nxt;
    logic          r_ready;
    logic          r_active;
    logic          r_done;
    logic [3:0]    w_nib;
    logic [7:0]    w_hex;
    logic [7:0]    w_char;
    logic [7:0]    w_cnt_inc;

    assign w_nib     = r_shift[DW-1 -: 4];
    assign w_hex     = (w_nib < 4'd10) ? {4'h3, w_nib} : (8'h57 + {4'h0, w_nib});
    assign w_cnt_inc = r_cnt + 8'd1;

    // Digest characters first, then CR and LF once the digest is exhausted
    always_comb begin
        w_char = 8'h0A;
        if (r_cnt < NDIG_C) begin
            w_char = HEX_ASCII ? w_hex : r_shift[DW-1 -: 8];
        end else if (r_cnt == NDIG_C) begin
            w_char = 8'h0D;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_data_nxt  = r_data;
        w_send_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (digest_valid && r_ready) begin
                    w_shift_nxt = digest;
                    w_cnt_nxt   = 8'd0;
                    w_next      = S_LOAD;
                end
            end
            S_LOAD: begin
                w_data_nxt = w_char;
                w_next     = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_send_nxt = 1'b1;
                    w_tmo_nxt  = '0;
                    w_next     = S_WSTART;
                end
            end
            S_WSTART: begin
                if (tx_busy || (r_tmo == TMO_LAST)) begin
                    w_next = S_WDONE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_WDONE: begin
                if (!tx_busy) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_shift_nxt = HEX_ASCII ? (r_shift << 4) : (r_shift << 8);
                    w_next      = (w_cnt_inc == TOTAL_C) ? S_FINISH : S_LOAD;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they are glitch-free
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= 8'd0;
            r_tmo    <= '0;
            r_data   <= 8'h00;
            r_send   <= 1'b0;
            r_ready  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tmo    <= w_tmo_nxt;
            r_data   <= w_data_nxt;
            r_send   <= w_send_nxt;
            r_ready  <= (w_next == S_IDLE);
            r_active <= (w_next != S_IDLE) && (w_next != S_FINISH);
            r_done   <= (w_next == S_FINISH);
        end
    end

    assign digest_ready = r_ready;
    assign tx_data      = r_data;
    assign tx_send      = r_send;
    assign active       = r_active;
    assign done         = r_done;

endmodule

// File: tb/tb_uart_digest_sender.sv
// Scoreboard bench: hex/CRLF instance plus a raw-byte instance, each with
// a small UART transmitter model driving the busy flag.
module tb_uart_digest_sender;

    localparam int ACK = 4;

    logic        clk;
    logic        rst;
    logic [31:0] digest0;
    logic        valid0, ready0, busy0, send0, active0, done0;
    logic [7:0]  data0;
    logic [15:0] digest1;
    logic        valid1, ready1, busy1, send1, active1, done1;
    logic [7:0]  data1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mode = 0;
    int hold0 = 10;
    logic force_busy = 1'b0;
    int bcnt0 = 0;
    int bcnt1 = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int sent0 = 0, sent1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int cap_cyc0 = 0, last_send0 = 0;
    bit first0 = 0, lat_ok0 = 0, rdy_pend0 = 0;
    bit prev_send0 = 0, prev_send1 = 0;

    uart_digest_sender #(
        .NUM_BYTES(4), .HEX_ASCII(1'b1), .APPEND_CRLF(1'b1), .ACK_TIMEOUT(ACK)
    ) u0 (
        .clk(clk), .rst(rst), .digest(digest0), .digest_valid(valid0),
        .digest_ready(ready0), .tx_busy(busy0), .tx_data(data0),
        .tx_send(send0), .active(active0), .done(done0)
    );

    uart_digest_sender #(
        .NUM_BYTES(2), .HEX_ASCII(1'b0), .APPEND_CRLF(1'b0), .ACK_TIMEOUT(ACK)
    ) u1 (
        .clk(clk), .rst(rst), .digest(digest1), .digest_valid(valid1),
        .digest_ready(ready1), .tx_busy(busy1), .tx_data(data1),
        .tx_send(send1), .active(active1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter models: busy rises right after a sampled send and holds
    always @(posedge clk) begin
        if (send0 && mode == 0) bcnt0 <= hold0;
        else if (bcnt0 > 0) bcnt0 <= bcnt0 - 1;
        if (send1) bcnt1 <= 3;
        else if (bcnt1 > 0) bcnt1 <= bcnt1 - 1;
    end
    assign busy0 = (bcnt0 != 0) || force_busy;
    assign busy1 = (bcnt1 != 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(97 + n - 10);
    endfunction

    // Reference: bytes MSB first, each as two hex digits, then CR LF
    task automatic push_exp0(input logic [31:0] d);
        for (int b = 3; b >= 0; b--) begin
            int v = int'((d >> (8 * b)) & 32'hFF);
            exp0.push_back(hexc(v / 16));
            exp0.push_back(hexc(v % 16));
        end
        exp0.push_back(8'h0D);
        exp0.push_back(8'h0A);
    endtask

    always @(negedge clk) begin
        if (rdy_pend0) begin
            chk("u0_ready_after_done", 32'(ready0), 1);
            rdy_pend0 = 0;
        end
        if (send0) begin
            sent0++;
            if (exp0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u0_send: unexpected char %h, want none", data0);
            end else begin
                chk("u0_char", 32'(data0), 32'(exp0.pop_front()));
            end
            chk("u0_send_protocol", {29'd0, busy0, prev_send0, active0}, 1);
            if (first0) begin
                if (lat_ok0) chk("u0_first_latency", 32'(cyc - cap_cyc0), 2);
                first0 = 0;
            end else if (mode == 1) begin
                chk("u0_timeout_gap", 32'(cyc - last_send0), ACK + 3);
            end
            last_send0 = cyc;
        end
        prev_send0 = send0;
        if (done0) begin
            done_cnt0++;
            chk("u0_done_all_sent", 32'(exp0.size()), 0);
            chk("u0_done_active", 32'(active0), 0);
            rdy_pend0 = 1;
        end
    end

    always @(negedge clk) begin
        if (send1) begin
            sent1++;
            if (exp1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL u1_send: unexpected byte %h, want none", data1);
            end else begin
                chk("u1_byte", 32'(data1), 32'(exp1.pop_front()));
            end
            chk("u1_send_protocol", {29'd0, busy1, prev_send1, active1}, 1);
        end
        prev_send1 = send1;
        if (done1) begin
            done_cnt1++;
            chk("u1_done_all_sent", 32'(exp1.size()), 0);
            chk("u1_done_active", 32'(active1), 0);
        end
    end

    task automatic give0(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        digest0 = d;
        valid0 = 1'b1;
        while (!ready0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready0) begin
            total++;
            bad++;
            $display("FAIL u0_capture: ready never rose, want capture of %h", d);
            valid0 = 1'b0;
            return;
        end
        push_exp0(d);
        cap_cyc0 = cyc + 1;
        first0 = 1;
        lat_ok0 = !force_busy;
        @(negedge clk);
        valid0 = 1'b0;
        digest0 = $urandom();
    endtask

    task automatic give1(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        digest1 = d;
        valid1 = 1'b1;
        while (!ready1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!ready1) begin
            total++;
            bad++;
            $display("FAIL u1_capture: ready never rose, want capture of %h", d);
            valid1 = 1'b0;
            return;
        end
        exp1.push_back(d[15:8]);
        exp1.push_back(d[7:0]);
        @(negedge clk);
        valid1 = 1'b0;
        digest1 = 16'($urandom());
    endtask

    task automatic wait_done0(input int target);
        int n = 0;
        while (done_cnt0 < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("u0_done_seen", 32'(done_cnt0 >= target), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done1(input int target);
        int n = 0;
        while (done_cnt1 < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("u1_done_seen", 32'(done_cnt1 >= target), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s;
        int d;
        int n;
        rst = 1'b0;
        valid0 = 1'b0;
        digest0 = '0;
        valid1 = 1'b0;
        digest1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready0), 0);
        chk("rst_send", 32'(send0), 0);
        chk("rst_data", 32'(data0), 0);
        chk("rst_active", 32'(active0), 0);
        chk("rst_done", 32'(done0), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(ready0), 1);

        // Known digest, then a second one held off until the first is done
        give0(32'h1234ABCD);
        d = done_cnt0;
        give0(32'hDEADBEEF);
        chk("t3_second_after_done", 32'(done_cnt0), 32'(d + 1));
        wait_done0(2);

        for (int i = 0; i < 4; i++) begin
            hold0 = int'($urandom_range(1, 12));
            give0($urandom());
            wait_done0(3 + i);
        end
        hold0 = 10;

        // Transmitter never acknowledges: every character times out
        mode = 1;
        give0($urandom());
        wait_done0(7);
        mode = 0;

        // Busy held before capture: nothing may be sent until it falls
        s = sent0;
        force_busy = 1'b1;
        repeat (20) @(negedge clk);
        give0(32'h1234ABCD);
        repeat (5) @(negedge clk);
        chk("t6_no_send_while_busy", 32'(sent0 - s), 0);
        force_busy = 1'b0;
        wait_done0(8);

        give1(16'hFF00);
        wait_done1(1);
        give1(16'($urandom()));
        wait_done1(2);

        // Reset while the fourth character is in flight
        s = sent0;
        give0($urandom());
        n = 0;
        while (sent0 < s + 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_four_sent", 32'(sent0 - s), 4);
        @(negedge clk);
        exp0.delete();
        first0 = 0;
        d = done_cnt0;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_send_low", 32'(send0), 0);
        chk("t5_done_low", 32'(done0), 0);
        chk("t5_active_low", 32'(active0), 0);
        chk("t5_ready_low", 32'(ready0), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_back", 32'(ready0), 1);
        s = sent0;
        repeat (40) @(negedge clk);
        chk("t5_no_more_sends", 32'(sent0 - s), 0);
        chk("t5_no_done", 32'(done_cnt0 - d), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
